neuron_state_sequencer: RTL and testbench

Time-multiplexes one neuron update pipe across N_NEURONS neurons. Holds per-neuron membrane (v), recovery (u) and input current (I) state in fixed-point register arrays. On each simulation step it streams every neuron's state into the pipe, captures the returned v/u/spike and writes them back. It then publishes a per-step spike vector. It sits directly upstream and downstream of the neuron update pipe, closing the v/u feedback loop in hardware.

---
 rtl/neuron_state_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_neuron_state_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_state_sequencer.sv
`default_nettype none
// ============================================================================
// neuron_state_sequencer : streams per-neuron v/u/I state through one shared
// neuron update pipe each step and writes the returned v/u/spike back.
// Optional feature macro: NSEQ_SPIKE_EVT_EN (per-spike event strobe).
// Revision: 1.0
// ============================================================================
module neuron_state_sequencer #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16,
  parameter int N_NEURONS = 16,
  parameter int IDX_W     = 4,
  parameter int PIPE_LAT  = 1,
  parameter logic signed [WIDTH-1:0] V_INIT = -32'sd4259840
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_start,
  output logic                    step_busy,
  output logic                    step_done,
  output logic [15:0]             step_cnt,
  input  logic                    i_wr_en,
  input  logic [IDX_W-1:0]        i_wr_idx,
  input  logic signed [WIDTH-1:0] i_wr_data,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic signed [WIDTH-1:0] rd_v,
  output logic signed [WIDTH-1:0] rd_u,
  output logic                    pipe_en,
  output logic signed [WIDTH-1:0] pipe_v,
  output logic signed [WIDTH-1:0] pipe_u,
  output logic signed [WIDTH-1:0] pipe_i,
  input  logic signed [WIDTH-1:0] pipe_v_ret,
  input  logic signed [WIDTH-1:0] pipe_u_ret,
  input  logic                    pipe_spike_ret,
  output logic [N_NEURONS-1:0]    spike_vec,
  output logic                    evt_valid,
  output logic [IDX_W-1:0]        evt_idx
);

  if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
    $error("FRAC must lie inside the state word");
  end
  if (N_NEURONS < 2 || (1 << IDX_W) < N_NEURONS) begin : g_bad_idx
    $error("IDX_W too narrow for N_NEURONS, or N_NEURONS < 2");
  end
  if (PIPE_LAT < 1) begin : g_bad_lat
    $error("PIPE_LAT must be at least 1");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    step_busy_q;
  logic                    step_done_q;
  logic [15:0]             step_cnt_q;
  logic [N_NEURONS-1:0]    spike_acc_q;
  logic [N_NEURONS-1:0]    spike_vec_q;
  logic signed [WIDTH-1:0] v_mem_q [N_NEURONS];
  logic signed [WIDTH-1:0] u_mem_q [N_NEURONS];
  logic signed [WIDTH-1:0] i_mem_q [N_NEURONS];
  logic                    trk_vld_q [PIPE_LAT];
  logic [IDX_W-1:0]        trk_idx_q [PIPE_LAT];

  logic             ret_vld;
  logic [IDX_W-1:0] ret_idx;
  logic             trk_upstream;
  logic             wr_in_range;
  logic             rd_in_range;

  assign ret_vld     = trk_vld_q[PIPE_LAT-1];
  assign ret_idx     = trk_idx_q[PIPE_LAT-1];
  assign wr_in_range = (32'(i_wr_idx) < N_NEURONS);
  assign rd_in_range = (32'(rd_idx) < N_NEURONS);

  // The last stage is captured at this edge, so only earlier stages keep DRAIN alive.
  always_comb begin
    trk_upstream = 1'b0;
    for (int k = 0; k < PIPE_LAT - 1; k++) begin
      trk_upstream = trk_upstream | trk_vld_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      step_busy_q <= 1'b0;
      step_done_q <= 1'b0;
      step_cnt_q  <= '0;
      spike_acc_q <= '0;
      spike_vec_q <= '0;
      for (int k = 0; k < PIPE_LAT; k++) begin
        trk_vld_q[k] <= 1'b0;
        trk_idx_q[k] <= '0;
      end
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem_q[k] <= V_INIT;
        u_mem_q[k] <= '0;
        i_mem_q[k] <= '0;
      end
    end else begin
      step_done_q  <= 1'b0;
      trk_vld_q[0] <= (state_q == S_ISSUE);
      trk_idx_q[0] <= idx_q;
      for (int k = 1; k < PIPE_LAT; k++) begin
        trk_vld_q[k] <= trk_vld_q[k-1];
        trk_idx_q[k] <= trk_idx_q[k-1];
      end

      case (state_q)
        S_IDLE: begin
          if (step_start) begin
            state_q     <= S_ISSUE;
            idx_q       <= '0;
            step_busy_q <= 1'b1;
            spike_acc_q <= '0;
          end
        end
        S_ISSUE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_DRAIN;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          if (!trk_upstream) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          step_busy_q <= 1'b0;
          step_done_q <= 1'b1;
          spike_vec_q <= spike_acc_q;
          step_cnt_q  <= step_cnt_q + 16'd1;
        end
        default: state_q <= S_IDLE;
      endcase

      if (ret_vld) begin
        v_mem_q[ret_idx]     <= pipe_v_ret;
        u_mem_q[ret_idx]     <= pipe_u_ret;
        spike_acc_q[ret_idx] <= pipe_spike_ret;
      end

      if (i_wr_en && wr_in_range) begin
        i_mem_q[i_wr_idx] <= i_wr_data;
      end
    end
  end

  assign step_busy = step_busy_q;
  assign step_done = step_done_q;
  assign step_cnt  = step_cnt_q;
  assign spike_vec = spike_vec_q;
  assign pipe_en   = (state_q == S_ISSUE);
  assign pipe_v    = v_mem_q[idx_q];
  assign pipe_u    = u_mem_q[idx_q];
  assign pipe_i    = i_mem_q[idx_q];
  assign rd_v      = rd_in_range ? v_mem_q[rd_idx] : '0;
  assign rd_u      = rd_in_range ? u_mem_q[rd_idx] : '0;

`ifdef NSEQ_SPIKE_EVT_EN
  logic             evt_valid_q;
  logic [IDX_W-1:0] evt_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
    end else begin
      evt_valid_q <= ret_vld && pipe_spike_ret;
      evt_idx_q   <= ret_idx;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_idx   = evt_idx_q;
`else
  assign evt_valid = 1'b0;
  assign evt_idx   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_neuron_state_sequencer.sv
`default_nettype none
// tb_neuron_state_sequencer : drives a PIPE_LAT=1 and a PIPE_LAT=3 instance and
// checks them against an array-based per-step model of the neuron state.
module tb_neuron_state_sequencer;
  localparam int N = 16;
  localparam int W = 32;
  localparam logic signed [W-1:0] VI = -32'sd4259840;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, step_start, step_start3;
  logic                i_wr_en;
  logic [3:0]          i_wr_idx, rd_idx;
  logic signed [W-1:0] i_wr_data;

  logic                busy1, done1, pen1, ps_ret1, evt1;
  logic [15:0]         cnt1;
  logic signed [W-1:0] rdv1, rdu1, pv1, pu1, pi1, pv_ret1, pu_ret1;
  logic [N-1:0]        spk1;
  logic [3:0]          evti1;

  logic                busy3, done3, pen3, evt3;
  logic [15:0]         cnt3;
  logic signed [W-1:0] rdv3, rdu3, pv3, pu3, pi3;
  logic [N-1:0]        spk3;
  logic [3:0]          evti3;
  logic signed [W-1:0] p3v [3];
  logic signed [W-1:0] p3u [3];
  logic                p3s [3];

  neuron_state_sequencer dut1 (
    .clk(clk), .rst(rst), .step_start(step_start), .step_busy(busy1), .step_done(done1),
    .step_cnt(cnt1), .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
    .rd_idx(rd_idx), .rd_v(rdv1), .rd_u(rdu1), .pipe_en(pen1), .pipe_v(pv1), .pipe_u(pu1),
    .pipe_i(pi1), .pipe_v_ret(pv_ret1), .pipe_u_ret(pu_ret1), .pipe_spike_ret(ps_ret1),
    .spike_vec(spk1), .evt_valid(evt1), .evt_idx(evti1));

  neuron_state_sequencer #(.PIPE_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .step_start(step_start3), .step_busy(busy3), .step_done(done3),
    .step_cnt(cnt3), .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
    .rd_idx(rd_idx), .rd_v(rdv3), .rd_u(rdu3), .pipe_en(pen3), .pipe_v(pv3), .pipe_u(pu3),
    .pipe_i(pi3), .pipe_v_ret(p3v[2]), .pipe_u_ret(p3u[2]), .pipe_spike_ret(p3s[2]),
    .spike_vec(spk3), .evt_valid(evt3), .evt_idx(evti3));

  // Neuron pipe stand-ins: v' = v + 1 + I, u' = u + 2, spike = I is odd.
  always_ff @(posedge clk) begin
    if (pen1) begin
      pv_ret1 <= pv1 + 32'sd1 + pi1;
      pu_ret1 <= pu1 + 32'sd2;
      ps_ret1 <= pi1[0];
    end
  end

  always_ff @(posedge clk) begin
    p3v[0] <= pv3 + 32'sd1 + pi3;
    p3u[0] <= pu3 + 32'sd2;
    p3s[0] <= pi3[0];
    for (int k = 1; k < 3; k++) begin
      p3v[k] <= p3v[k-1];
      p3u[k] <= p3u[k-1];
      p3s[k] <= p3s[k-1];
    end
  end

  logic                sel3;
  logic                m_busy, m_done, m_pen, m_evt;
  logic [15:0]         m_cnt;
  logic signed [W-1:0] m_rdv, m_rdu, m_pv, m_pu, m_pi;
  logic [N-1:0]        m_spk;
  logic [3:0]          m_evti;
  assign m_busy = sel3 ? busy3 : busy1;
  assign m_done = sel3 ? done3 : done1;
  assign m_pen  = sel3 ? pen3  : pen1;
  assign m_evt  = sel3 ? evt3  : evt1;
  assign m_evti = sel3 ? evti3 : evti1;
  assign m_cnt  = sel3 ? cnt3  : cnt1;
  assign m_rdv  = sel3 ? rdv3  : rdv1;
  assign m_rdu  = sel3 ? rdu3  : rdu1;
  assign m_pv   = sel3 ? pv3   : pv1;
  assign m_pu   = sel3 ? pu3   : pu1;
  assign m_pi   = sel3 ? pi3   : pi1;
  assign m_spk  = sel3 ? spk3  : spk1;

  // Reference model of the neuron state, advanced once per completed step.
  logic signed [W-1:0] mv [N];
  logic signed [W-1:0] mu [N];
  logic signed [W-1:0] mi [N];
  logic [15:0]         exp_cnt;
  logic [N-1:0]        exp_spk;
  int                  n_tests, n_fail;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = VI;
      mu[k] = '0;
      mi[k] = '0;
    end
    exp_cnt = '0;
    exp_spk = '0;
  endtask

  task automatic write_i(input int idx, input logic signed [W-1:0] data);
    i_wr_en   = 1'b1;
    i_wr_idx  = 4'(idx);
    i_wr_data = data;
    @(negedge clk);
    i_wr_en = 1'b0;
    mi[idx] = data;
  endtask

  task automatic check_all_rd();
    for (int k = 0; k < N; k++) begin
      rd_idx = 4'(k);
      #1;
      n_tests++;
      if (m_rdv !== mv[k] || m_rdu !== mu[k]) begin
        n_fail++;
        $display("FAIL rd_state lat=%0d idx=%0d v=%0d u=%0d expected v=%0d u=%0d",
                 sel3 ? 3 : 1, k, m_rdv, m_rdu, mv[k], mu[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string nm);
    n_tests++;
    if (m_spk !== '0 || m_cnt !== 16'd0 || m_busy !== 1'b0 || m_done !== 1'b0 ||
        m_pen !== 1'b0 || m_evt !== 1'b0) begin
      n_fail++;
      $display("FAIL %s spike_vec=%h cnt=%0d busy=%b done=%b pipe_en=%b evt=%b expected all zero",
               nm, m_spk, m_cnt, m_busy, m_done, m_pen, m_evt);
    end
  endtask

  // Runs one step from a negedge and ends at the negedge of the step_done cycle.
  task automatic run_step(input bit hold, input bit mid_wr, input int mid_idx,
                          input logic signed [W-1:0] mid_data);
    logic signed [W-1:0] pv [N];
    logic signed [W-1:0] pu [N];
    logic signed [W-1:0] pi [N];
    logic [N-1:0]        spk;
    logic [N-1:0]        evt_m;
    int                  evt_n, d;
    logic                e_en, e_busy, e_done;
    d = N + (sel3 ? 3 : 1) + 1;
    for (int k = 0; k < N; k++) begin
      pv[k] = mv[k];
      pu[k] = mu[k];
      pi[k] = mi[k];
    end
    evt_n = 0;
    evt_m = '0;
    if (sel3) step_start3 = 1'b1;
    else      step_start  = 1'b1;
    for (int c = 1; c <= d + 1; c++) begin
      @(negedge clk);
      e_en   = (c <= N);
      e_busy = (c <= d);
      e_done = (c == d + 1);
      n_tests++;
      if (m_pen !== e_en || m_busy !== e_busy || m_done !== e_done) begin
        n_fail++;
        $display("FAIL step_ctl lat=%0d c=%0d pipe_en=%b busy=%b done=%b expected %b %b %b",
                 sel3 ? 3 : 1, c, m_pen, m_busy, m_done, e_en, e_busy, e_done);
      end
      if (c <= N) begin
        n_tests++;
        if (m_pv !== pv[c-1] || m_pu !== pu[c-1] || m_pi !== pi[c-1]) begin
          n_fail++;
          $display("FAIL operands lat=%0d slot=%0d v=%0d u=%0d i=%0d expected %0d %0d %0d",
                   sel3 ? 3 : 1, c - 1, m_pv, m_pu, m_pi, pv[c-1], pu[c-1], pi[c-1]);
        end
      end
      if (m_evt === 1'b1) begin
        evt_n++;
        evt_m[m_evti] = 1'b1;
      end
      if (c == 1 && !hold) begin
        step_start  = 1'b0;
        step_start3 = 1'b0;
      end
      i_wr_en   = mid_wr && (c == mid_idx + 1);
      i_wr_idx  = 4'(mid_idx);
      i_wr_data = mid_data;
    end
    i_wr_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      spk[k] = pi[k][0];
      mv[k]  = pv[k] + 32'sd1 + pi[k];
      mu[k]  = pu[k] + 32'sd2;
    end
    if (mid_wr) mi[mid_idx] = mid_data;
    exp_cnt = exp_cnt + 16'd1;
    exp_spk = spk;
    n_tests++;
    if (m_spk !== exp_spk || m_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL step_result lat=%0d spike_vec=%h cnt=%0d expected %h %0d",
               sel3 ? 3 : 1, m_spk, m_cnt, exp_spk, exp_cnt);
    end
    n_tests++;
`ifdef NSEQ_SPIKE_EVT_EN
    if (evt_n != $countones(spk) || evt_m !== spk) begin
      n_fail++;
      $display("FAIL spike_evt lat=%0d pulses=%0d mask=%h expected %0d %h",
               sel3 ? 3 : 1, evt_n, evt_m, $countones(spk), spk);
    end
`else
    if (evt_n != 0) begin
      n_fail++;
      $display("FAIL spike_evt lat=%0d pulses=%0d expected 0", sel3 ? 3 : 1, evt_n);
    end
`endif
  endtask

  task automatic test_reset();
    sel3 = 1'b0;
    check_idle("reset_lat1");
    check_all_rd();
    sel3 = 1'b1;
    check_idle("reset_lat3");
    check_all_rd();
    sel3 = 1'b0;
  endtask

  task automatic test_single_step();
    sel3 = 1'b0;
    write_i(3, 32'sd1);
    run_step(1'b0, 1'b0, 0, '0);
    check_all_rd();
  endtask

  task automatic test_i_write();
    sel3 = 1'b0;
    write_i(5, 32'sd655360);
    run_step(1'b0, 1'b1, 5, 32'sd12345);
    check_all_rd();
    run_step(1'b0, 1'b0, 0, '0);
    check_all_rd();
  endtask

  task automatic test_back_to_back();
    sel3 = 1'b0;
    run_step(1'b1, 1'b0, 0, '0);
    run_step(1'b0, 1'b0, 0, '0);
    check_all_rd();
  endtask

  task automatic test_random_steps();
    sel3 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++) begin
        write_i(int'($urandom_range(0, N - 1)), $urandom);
      end
      run_step(1'b0, 1'b1, int'($urandom_range(0, N - 1)), $urandom);
      check_all_rd();
    end
  endtask

  task automatic test_reset_mid_step();
    bit seen;
    step_start  = 1'b1;
    step_start3 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        step_start  = 1'b0;
        step_start3 = 1'b0;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done1 !== 1'b0 || done3 !== 1'b0 || busy1 !== 1'b0 || busy3 !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_reset_activity seen=%b expected 0", seen);
    end
    sel3 = 1'b0;
    check_idle("mid_reset_lat1");
    check_all_rd();
    sel3 = 1'b1;
    check_idle("mid_reset_lat3");
    check_all_rd();
  endtask

  task automatic test_pipe_lat3();
    sel3 = 1'b1;
    write_i(3, 32'sd1);
    run_step(1'b0, 1'b0, 0, '0);
    check_all_rd();
    write_i(7, 32'sd655360);
    run_step(1'b0, 1'b0, 0, '0);
    check_all_rd();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    sel3        = 1'b0;
    rst         = 1'b1;
    step_start  = 1'b0;
    step_start3 = 1'b0;
    i_wr_en     = 1'b0;
    i_wr_idx    = '0;
    i_wr_data   = '0;
    rd_idx      = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_step();
    test_i_write();
    test_back_to_back();
    test_random_steps();
    test_reset_mid_step();
    test_pipe_lat3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
